// File: rtl/snoop_grant_ctrl_pkg.sv
// snoop_grant_ctrl_pkg: shared FSM state encoding and width helper for the snoop grant controller
package snoop_grant_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, HELD = 2'd1, DROP = 2'd2} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) if ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/snoop_grant_ctrl_tag_decode.sv
// snoop_grant_ctrl_tag_decode: tag to one-hot agent select, all-zero when the tag is out of range
module snoop_grant_ctrl_tag_decode #(
  parameter int N      = 4,
  parameter int TAG_SZ = 5
) (
  input  logic [TAG_SZ-1:0] tag,
  output logic [N-1:0]      oh
);
  always_comb begin
    oh = '0;
    for (int i = 0; i < N; i++) oh[i] = tag == TAG_SZ'(i);
  end
endmodule

// File: rtl/snoop_grant_ctrl.sv
// snoop_grant_ctrl: acks the tag-tree winner, steers one packet to it, pulses its done on the last beat
// Optional SNOOP_GRANT_STATS_EN adds pkt_cnt/drop_cnt packet counters.
module snoop_grant_ctrl
  import snoop_grant_ctrl_pkg::*;
#(
  parameter int N          = 4,
  parameter int TAG_SZ     = 5,
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [TAG_SZ-1:0]     tag,
  input  logic                  rdy,
  output logic                  ack,
  output logic                  sn_rdy,
  input  logic                  in_en,
  input  logic [ADDR_WIDTH-1:0] in_addr,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_done,
  output logic [N-1:0]          wr_en,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  output logic [N-1:0]          done
`ifdef SNOOP_GRANT_STATS_EN
  ,
  output logic [31:0]           pkt_cnt,
  output logic [31:0]           drop_cnt
`endif
);
  if (TAG_SZ < clog2(N)) begin : g_tag_chk
    $error("snoop_grant_ctrl: TAG_SZ too narrow for N");
  end
  state_t st, nx;
  logic [TAG_SZ-1:0] sel;
  logic [N-1:0] oh;
  logic beat;
  snoop_grant_ctrl_tag_decode #(.N(N), .TAG_SZ(TAG_SZ)) u_dec (.tag(sel), .oh(oh));
  always_ff @(posedge clk) st <= rst ? IDLE : nx;
  // a beat arriving while idle has priority over a pending grant and starts a drop
  always_comb begin
    nx = st == IDLE ? (in_en ? (in_done ? IDLE : DROP) : (rdy ? HELD : IDLE))
                    : ((in_en && in_done) ? IDLE : st);
  end
  always_comb begin
    ack    = st == IDLE && rdy && !in_en;
    sn_rdy = st == HELD;
    beat   = sn_rdy && in_en;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sel     <= '0;
      wr_en   <= '0;
      done    <= '0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      if (ack) sel <= tag;
      wr_en <= beat ? oh : '0;
      done  <= (beat && in_done) ? oh : '0;
      if (beat) begin
        wr_addr <= in_addr;
        wr_data <= in_data;
      end
    end
  end
  always_ff @(posedge clk)
    if (!rst && ack) assert (int'(tag) < N) else $error("snoop_grant_ctrl: tag %0d out of range", tag);
`ifdef SNOOP_GRANT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_cnt  <= '0;
      drop_cnt <= '0;
    end else if (in_en && in_done) begin
      if (st == HELD) pkt_cnt <= pkt_cnt + 32'd1;
      else drop_cnt <= drop_cnt + 32'd1;
    end
  end
`endif
endmodule
